oam_dma: RTL and testbench



---
 rtl/nes_bus_pkg.sv | 39 +++
 rtl/oam_dma.sv | 161 ++++++++++++++++
 tb/tb_oam_dma.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/nes_bus_pkg.sv
// ---------------------------------------------------------------------------
// nes_bus_pkg
// Shared CPU-bus definitions for the NES bus-side blocks.
//   - Default trigger ($4014) and OAMDATA ($2004) addresses.
//   - Sprite-DMA state encoding, both as raw 3-bit constants and as an enum.
//   - Small decode helpers for the DMA control outputs.
// ---------------------------------------------------------------------------
package nes_bus_pkg;

  localparam logic [15:0] TRIG_ADDR_DEF = 16'h4014;
  localparam logic [15:0] OAM_ADDR_DEF  = 16'h2004;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_REQ   = 3'd1;
  localparam logic [2:0] ST_HALT  = 3'd2;
  localparam logic [2:0] ST_ALIGN = 3'd3;
  localparam logic [2:0] ST_RD    = 3'd4;
  localparam logic [2:0] ST_WR    = 3'd5;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    REQ   = ST_REQ,
    HALT  = ST_HALT,
    ALIGN = ST_ALIGN,
    RD    = ST_RD,
    WR    = ST_WR
  } dma_state_e;

  // CPU must be held in every non-idle state.
  function automatic logic state_req(input dma_state_e s);
    return (s != IDLE);
  endfunction

  // DMA owns the bus from the first dummy cycle until the last write.
  function automatic logic state_active(input dma_state_e s);
    return (s == HALT) || (s == ALIGN) || (s == RD) || (s == WR);
  endfunction

endpackage

// File: rtl/oam_dma.sv
// ---------------------------------------------------------------------------
// oam_dma
// Sprite DMA initiator. A CPU write to TRIG_ADDR with page P halts the CPU
// and copies $P00-$PFF into OAM as 256 read/write pairs, each write going to
// OAM_ADDR. All outputs are registered (decoded from the next state).
//
// Configuration macro: OAM_DMA_ALIGN_EN
//   defined   : an extra ALIGN dummy cycle follows HALT when the free-running
//               parity bit is 1 (513/514-cycle transfers).
//   undefined : ALIGN is never entered (always 513 cycles).
//
// Ports:
//   i_cpu_clk    in  1  CPU clock, rising edge
//   i_cpu_rst    in  1  async active-high reset
//   i_bus_addr   in  16 snooped CPU bus address
//   i_bus_wn     in  1  CPU write-not (0 = write)
//   i_bus_wdata  in  8  CPU write data (page number on trigger)
//   o_dma_req    out 1  halt request to CPU core
//   i_cpu_halted in  1  CPU stopped and released the bus
//   o_dma_active out 1  DMA owns the bus (bus mux select)
//   o_dma_addr   out 16 DMA bus address
//   o_dma_wn     out 1  DMA write-not
//   o_dma_wdata  out 8  DMA write data
//   i_dma_rdata  in  8  bus read data, same cycle as read address
// ---------------------------------------------------------------------------
module oam_dma
  import nes_bus_pkg::*;
#(
  parameter logic [15:0] TRIG_ADDR = TRIG_ADDR_DEF,
  parameter logic [15:0] OAM_ADDR  = OAM_ADDR_DEF
) (
  input  logic        i_cpu_clk,
  input  logic        i_cpu_rst,
  input  logic [15:0] i_bus_addr,
  input  logic        i_bus_wn,
  input  logic [7:0]  i_bus_wdata,
  output logic        o_dma_req,
  input  logic        i_cpu_halted,
  output logic        o_dma_active,
  output logic [15:0] o_dma_addr,
  output logic        o_dma_wn,
  output logic [7:0]  o_dma_wdata,
  input  logic [7:0]  i_dma_rdata
);

  dma_state_e  state;
  dma_state_e  next_state;
  logic [7:0]  cnt;
  logic [7:0]  cnt_next;
  logic [7:0]  page;
  logic        parity;
  logic        trigger;
  logic        req_next;
  logic        active_next;
  logic [15:0] addr_next;
  logic        wn_next;

  assign trigger = (i_bus_addr == TRIG_ADDR) && (i_bus_wn == 1'b0);

  // Next-state and counter logic.
  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (trigger) begin
          next_state = REQ;
          cnt_next   = 8'h00;
        end else begin
          next_state = IDLE;
        end
      end
      REQ: begin
        if (i_cpu_halted) begin
          next_state = HALT;
        end else begin
          next_state = REQ;
        end
      end
      HALT: begin
`ifdef OAM_DMA_ALIGN_EN
        if (parity) begin
          next_state = ALIGN;
        end else begin
          next_state = RD;
        end
`else
        next_state = RD;
`endif
      end
      ALIGN: next_state = RD;
      RD:    next_state = WR;
      WR: begin
        if (cnt == 8'hFF) begin
          next_state = IDLE;
        end else begin
          next_state = RD;
          cnt_next   = cnt + 8'd1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Output values for the cycle after the coming edge, decoded from next_state
  // so the outputs themselves can be plain registers. The page is already
  // latched by the time any RD is reached, so page (not i_bus_wdata) is used.
  always_comb begin
    req_next    = state_req(next_state);
    active_next = state_active(next_state);
    wn_next     = 1'b1;
    addr_next   = 16'h0000;
    case (next_state)
      HALT, ALIGN: addr_next = OAM_ADDR;
      RD:          addr_next = {page, cnt_next};
      WR: begin
        addr_next = OAM_ADDR;
        wn_next   = 1'b0;
      end
      default: addr_next = 16'h0000;
    endcase
  end

  // State, counter, page and free-running parity registers.
  always_ff @(posedge i_cpu_clk or posedge i_cpu_rst) begin
    if (i_cpu_rst) begin
      state  <= IDLE;
      cnt    <= 8'h00;
      page   <= 8'h00;
      parity <= 1'b0;
    end else begin
      state  <= next_state;
      cnt    <= cnt_next;
      parity <= ~parity;
      if ((state == IDLE) && trigger) begin
        page <= i_bus_wdata;
      end
    end
  end

  // Registered bus and control outputs; read data is captured at the edge
  // closing RD and presented during the following WR.
  always_ff @(posedge i_cpu_clk or posedge i_cpu_rst) begin
    if (i_cpu_rst) begin
      o_dma_req    <= 1'b0;
      o_dma_active <= 1'b0;
      o_dma_addr   <= 16'h0000;
      o_dma_wn     <= 1'b1;
      o_dma_wdata  <= 8'h00;
    end else begin
      o_dma_req    <= req_next;
      o_dma_active <= active_next;
      o_dma_addr   <= addr_next;
      o_dma_wn     <= wn_next;
      if (state == RD) begin
        o_dma_wdata <= i_dma_rdata;
      end
    end
  end

endmodule

// File: tb/tb_oam_dma.sv
// ---------------------------------------------------------------------------
// tb_oam_dma
// Self-checking bench for oam_dma. Table-driven transfers, randomized
// transfers and hand-written corner sequences; every active bus cycle is
// compared against a transaction list built from the transfer rules.
// ---------------------------------------------------------------------------
module tb_oam_dma;

  localparam logic [15:0] OAM = 16'h2004;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] bus_addr;
  logic        bus_wn;
  logic [7:0]  bus_wdata;
  logic        cpu_halted;
  logic        dma_req;
  logic        dma_active;
  logic [15:0] dma_addr;
  logic        dma_wn;
  logic [7:0]  dma_wdata;
  logic [7:0]  rdata;
  logic [7:0]  key;
  int          ecnt;
  int          checks = 0;
  int          errors = 0;

  typedef struct packed {
    logic [15:0] addr;
    logic        wn;
    logic [7:0]  wdata;
  } bus_rec_t;

  typedef struct {
    logic [7:0]  page;
    int          delay;
    logic [7:0]  key;
    int          pad;
    int          retrig;
    bit          final_trig;
    logic [15:0] exp_first;
    logic [15:0] exp_last;
  } vec_t;

  vec_t vecs[6];

  oam_dma dut (
    .i_cpu_clk    (clk),
    .i_cpu_rst    (rst),
    .i_bus_addr   (bus_addr),
    .i_bus_wn     (bus_wn),
    .i_bus_wdata  (bus_wdata),
    .o_dma_req    (dma_req),
    .i_cpu_halted (cpu_halted),
    .o_dma_active (dma_active),
    .o_dma_addr   (dma_addr),
    .o_dma_wn     (dma_wn),
    .o_dma_wdata  (dma_wdata),
    .i_dma_rdata  (rdata)
  );

  always #5 clk = ~clk;

  // Memory model: data is a function of the address low byte.
  always_comb rdata = dma_addr[7:0] ^ key;

  // Edges since reset; its LSB is the expected parity bit.
  always @(posedge clk or posedge rst) begin
    if (rst) ecnt <= 0;
    else     ecnt <= ecnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One complete transfer. rst_at >= 0 aborts with reset after that write.
  task automatic run_xfer(input logic [7:0] page, input int delay, input logic [7:0] k,
                          input int pad, input int retrig, input bit final_trig,
                          input int rst_at, output logic [15:0] first_rd,
                          output logic [15:0] last_rd);
    bus_rec_t got[$];
    bus_rec_t exp[$];
    bus_rec_t s;
    bit       par;
    bit       align;
    bit       aborted;
    bit       done;
    int       wr_cnt;
    int       nmis;
    int       dummy;
    int       n;

    got.delete();
    exp.delete();
    par = 1'b0;
    aborted = 1'b0;
    done = 1'b0;
    wr_cnt = 0;
    key = k;
    repeat (pad) @(posedge clk);

    // Trigger write, one cycle long.
    @(posedge clk); #1;
    bus_addr = 16'h4014; bus_wn = 1'b0; bus_wdata = page;
    @(posedge clk); #1;
    bus_addr = 16'h0000; bus_wn = 1'b1; bus_wdata = $urandom_range(0, 255);

    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      check("halt_wait", {dma_req, dma_active, dma_wn, dma_addr}, {1'b1, 1'b0, 1'b1, 16'h0000});
      @(posedge clk); #1;
    end
    cpu_halted = 1'b1;
    @(negedge clk);
    check("pre_active", {dma_req, dma_active}, {1'b1, 1'b0});

    for (int cyc = 0; cyc < 700; cyc++) begin
      @(negedge clk);
      bus_addr = 16'h0000; bus_wn = 1'b1;
      if (cyc == 0) begin
        check("act_latency", dma_active, 1'b1);
        par = ecnt[0];
      end
      if (!dma_active) begin
        done = 1'b1;
        break;
      end
      check("req_with_active", dma_req, 1'b1);
      s.addr = dma_addr; s.wn = dma_wn; s.wdata = dma_wdata;
      got.push_back(s);
      if (!dma_wn) begin
        wr_cnt++;
        if (wr_cnt == retrig || (final_trig && wr_cnt == 256)) begin
          bus_addr = 16'h4014; bus_wn = 1'b0; bus_wdata = 8'h07;
        end
        if (wr_cnt == rst_at) begin
          rst = 1'b1;
          aborted = 1'b1;
          break;
        end
      end
    end

    if (!done && !aborted) check("timeout", 1'b1, 1'b0);

    // Expected transaction list from the transfer rules.
`ifdef OAM_DMA_ALIGN_EN
    align = par;
`else
    align = 1'b0;
`endif
    dummy = align ? 2 : 1;
    for (int i = 0; i < dummy; i++) exp.push_back({OAM, 1'b1, 8'h00});
    for (int i = 0; i < 256; i++) begin
      exp.push_back({page, i[7:0], 1'b1, 8'h00});
      exp.push_back({OAM, 1'b0, i[7:0] ^ k});
    end

    nmis = 0;
    n = (got.size() < exp.size()) ? got.size() : exp.size();
    for (int i = 0; i < n; i++) begin
      if (got[i].addr !== exp[i].addr || got[i].wn !== exp[i].wn ||
          (!exp[i].wn && got[i].wdata !== exp[i].wdata)) begin
        if (nmis == 0)
          $display("FAIL xfer_cycle %0d: actual %h/%b/%h required %h/%b/%h", i,
                   got[i].addr, got[i].wn, got[i].wdata, exp[i].addr, exp[i].wn, exp[i].wdata);
        nmis++;
      end
    end
    check("xfer_seq_mismatches", nmis, 0);

    first_rd = (got.size() > dummy) ? got[dummy].addr : 16'h0000;
    last_rd  = (got.size() >= 2) ? got[got.size() - 2].addr : 16'h0000;

    if (aborted) begin
      @(negedge clk);
      check("reset_midop", {dma_req, dma_active, dma_wn, dma_addr, dma_wdata},
            {1'b0, 1'b0, 1'b1, 16'h0000, 8'h00});
      rst = 1'b0;
      cpu_halted = 1'b0;
    end else begin
      check("xfer_len", got.size(), exp.size());
      check("fall_idle", {dma_req, dma_active, dma_wn, dma_addr}, {1'b0, 1'b0, 1'b1, 16'h0000});
      cpu_halted = 1'b0;
      if (final_trig) begin
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check("final_trig_ignored", dma_req, 1'b0);
        end
      end
    end
  endtask

  initial begin
    logic [15:0] f;
    logic [15:0] l;
    logic [7:0]  pg;

    vecs[0] = '{8'h02, 0,  8'hA5, 0, -1,  1'b0, 16'h0200, 16'h02FF};
    vecs[1] = '{8'h03, 20, 8'h3C, 0, 100, 1'b0, 16'h0300, 16'h03FF};
    vecs[2] = '{8'hFF, 1,  8'h00, 0, -1,  1'b0, 16'hFF00, 16'hFFFF};
    vecs[3] = '{8'h20, 2,  8'h5A, 0, -1,  1'b1, 16'h2000, 16'h20FF};
    vecs[4] = '{8'h10, 0,  8'hC3, 0, -1,  1'b0, 16'h1000, 16'h10FF};
    vecs[5] = '{8'h10, 0,  8'hC3, 1, -1,  1'b0, 16'h1000, 16'h10FF};

    rst = 1'b1;
    bus_addr = 16'h0000; bus_wn = 1'b1; bus_wdata = 8'h00;
    cpu_halted = 1'b0;
    key = 8'h00;
    @(negedge clk);
    @(negedge clk);
    check("reset_state", {dma_req, dma_active, dma_wn, dma_addr, dma_wdata},
          {1'b0, 1'b0, 1'b1, 16'h0000, 8'h00});
    rst = 1'b0;

    // Table-driven transfers, each from a fresh reset so parity is known.
    for (int v = 0; v < 6; v++) begin
      apply_reset();
      run_xfer(vecs[v].page, vecs[v].delay, vecs[v].key, vecs[v].pad, vecs[v].retrig,
               vecs[v].final_trig, -1, f, l);
      check($sformatf("vec%0d_first_rd", v), f, vecs[v].exp_first);
      check($sformatf("vec%0d_last_rd", v), l, vecs[v].exp_last);
    end

    // Reset mid-transfer, then a fresh transfer must restart at cnt 0.
    run_xfer(8'h40, 0, 8'h11, 0, -1, 1'b0, 50, f, l);
    check("abort_last_rd", l, 16'h4031);
    run_xfer(8'h41, 1, 8'h22, 0, -1, 1'b0, -1, f, l);
    check("restart_first_rd", f, 16'h4100);
    check("restart_last_rd", l, 16'h41FF);

    // Randomized back-to-back transfers; parity follows from elapsed edges.
    for (int r = 0; r < 6; r++) begin
      pg = $urandom_range(0, 255);
      run_xfer(pg, $urandom_range(0, 4), $urandom_range(0, 255), $urandom_range(0, 1),
               -1, 1'b0, -1, f, l);
      check("rand_first_rd", f, {pg, 8'h00});
      check("rand_last_rd", l, {pg, 8'hFF});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
